// File: rtl/reorient_tri_pipe.sv
// Two-stage triangle reorienter: S1 registers the triangle and squared edge lengths follow from it,
// S2 picks the longest/shortest 2D edge and rotates vertices cyclically so that edge becomes PQ.
module reorient_tri_pipe #(
    parameter  int unsigned COORD_W = 16,
    localparam int unsigned TRI_W   = 9 * COORD_W
) (
    input  logic             clk,
    input  logic             n_rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             in_mode,
    input  logic [TRI_W-1:0] in_tri,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [TRI_W-1:0] out_tri,
    output logic [1:0]       out_rot,
    output logic             out_degenerate
);

    localparam int unsigned VTX_W  = 3 * COORD_W;
    localparam int unsigned DIF_W  = COORD_W + 1;
    localparam int unsigned SQ_W   = 2 * COORD_W + 2;
    localparam int unsigned DIST_W = 2 * COORD_W + 3;

    logic             r_s1_valid;
    logic             r_s1_mode;
    logic [TRI_W-1:0] r_s1_tri;
    logic             r_s2_valid;
    logic [TRI_W-1:0] r_s2_tri;
    logic [1:0]       r_s2_rot;
    logic             r_s2_degenerate;

    logic              w_s2_load;
    logic              w_accept;
    logic [VTX_W-1:0]  w_p;
    logic [VTX_W-1:0]  w_q;
    logic [VTX_W-1:0]  w_r;
    logic [DIST_W-1:0] w_d1;
    logic [DIST_W-1:0] w_d2;
    logic [DIST_W-1:0] w_d3;
    logic [1:0]        w_rot;
    logic [TRI_W-1:0]  w_rot_tri;
    logic              w_degenerate;

    // Exact squared 2D distance; z (low COORD_W bits of a vertex) is ignored.
    function automatic logic [DIST_W-1:0] sq_dist(input logic [VTX_W-1:0] a,
                                                   input logic [VTX_W-1:0] b);
        logic signed [DIF_W-1:0] dx;
        logic signed [DIF_W-1:0] dy;
        logic signed [SQ_W-1:0]  sx;
        logic signed [SQ_W-1:0]  sy;
        dx = DIF_W'(signed'(a[VTX_W-1 -: COORD_W])) - DIF_W'(signed'(b[VTX_W-1 -: COORD_W]));
        dy = DIF_W'(signed'(a[VTX_W-COORD_W-1 -: COORD_W]))
           - DIF_W'(signed'(b[VTX_W-COORD_W-1 -: COORD_W]));
        sx = SQ_W'(dx) * SQ_W'(dx);
        sy = SQ_W'(dy) * SQ_W'(dy);
        return DIST_W'(unsigned'(sx)) + DIST_W'(unsigned'(sy));
    endfunction

    assign w_s2_load = r_s1_valid && (!r_s2_valid || out_ready);
    assign in_ready  = !r_s1_valid || w_s2_load;
    assign w_accept  = in_valid && in_ready;

    assign w_p  = r_s1_tri[TRI_W-1 -: VTX_W];
    assign w_q  = r_s1_tri[2*VTX_W-1 -: VTX_W];
    assign w_r  = r_s1_tri[VTX_W-1:0];
    assign w_d1 = sq_dist(w_p, w_q);
    assign w_d2 = sq_dist(w_q, w_r);
    assign w_d3 = sq_dist(w_r, w_p);

    assign w_degenerate = (w_d1 == '0) || (w_d2 == '0) || (w_d3 == '0);

    // Edge selection; non-strict compares give the lowest index priority on ties.
    always_comb begin
        w_rot = 2'd0;
        if (!r_s1_mode) begin
            if (w_d1 >= w_d2 && w_d1 >= w_d3) w_rot = 2'd0;
            else if (w_d2 >= w_d3)            w_rot = 2'd1;
            else                              w_rot = 2'd2;
        end else begin
            if (w_d1 <= w_d2 && w_d1 <= w_d3) w_rot = 2'd0;
            else if (w_d2 <= w_d3)            w_rot = 2'd1;
            else                              w_rot = 2'd2;
        end
    end

    always_comb begin
        w_rot_tri = r_s1_tri;
        case (w_rot)
            2'd1:    w_rot_tri = {w_q, w_r, w_p};
            2'd2:    w_rot_tri = {w_r, w_p, w_q};
            default: w_rot_tri = r_s1_tri;
        endcase
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s1_valid <= 1'b0;
            r_s1_mode  <= 1'b0;
            r_s1_tri   <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1_mode  <= in_mode;
            r_s1_tri   <= in_tri;
        end else if (w_s2_load) begin
            r_s1_valid <= 1'b0;
        end
    end

    // Output register holds its payload while stalled.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            r_s2_valid      <= 1'b0;
            r_s2_tri        <= '0;
            r_s2_rot        <= 2'd0;
            r_s2_degenerate <= 1'b0;
        end else if (w_s2_load) begin
            r_s2_valid      <= 1'b1;
            r_s2_tri        <= w_rot_tri;
            r_s2_rot        <= w_rot;
            r_s2_degenerate <= w_degenerate;
        end else if (out_ready) begin
            r_s2_valid <= 1'b0;
        end
    end

    assign out_valid      = r_s2_valid;
    assign out_tri        = r_s2_tri;
    assign out_rot        = r_s2_rot;
    assign out_degenerate = r_s2_degenerate;

endmodule

// File: tb/tb_reorient_tri_pipe.sv
// Directed bench for reorient_tri_pipe: single-triangle latency/selection cases,
// a backpressured stream against hand-computed expectations, and mid-flight reset.
module tb_reorient_tri_pipe;

    localparam int unsigned COORD_W = 16;
    localparam int unsigned TRI_W   = 9 * COORD_W;

    logic             clk;
    logic             n_rst;
    logic             in_valid;
    logic             in_ready;
    logic             in_mode;
    logic [TRI_W-1:0] in_tri;
    logic             out_valid;
    logic             out_ready;
    logic [TRI_W-1:0] out_tri;
    logic [1:0]       out_rot;
    logic             out_degenerate;

    int tests;
    int fails;

    reorient_tri_pipe #(.COORD_W(COORD_W)) dut (
        .clk            (clk),
        .n_rst          (n_rst),
        .in_valid       (in_valid),
        .in_ready       (in_ready),
        .in_mode        (in_mode),
        .in_tri         (in_tri),
        .out_valid      (out_valid),
        .out_ready      (out_ready),
        .out_tri        (out_tri),
        .out_rot        (out_rot),
        .out_degenerate (out_degenerate)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [TRI_W-1:0] mk(input int px, input int py, input int pz,
                                            input int qx, input int qy, input int qz,
                                            input int rx, input int ry, input int rz);
        return {COORD_W'(px), COORD_W'(py), COORD_W'(pz),
                COORD_W'(qx), COORD_W'(qy), COORD_W'(qz),
                COORD_W'(rx), COORD_W'(ry), COORD_W'(rz)};
    endfunction

    task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
        tests++;
        assert (got === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    // One triangle through an idle pipeline with out_ready=1: checks 2-cycle latency and payload.
    task automatic run_single(input string tag, input logic mode, input logic [TRI_W-1:0] tri_in,
                              input logic [TRI_W-1:0] exp_tri, input logic [1:0] exp_rot,
                              input logic exp_deg);
        @(negedge clk);
        in_valid = 1'b1;
        in_mode  = mode;
        in_tri   = tri_in;
        #1;
        check({tag, "_ready"}, 256'(in_ready), 256'(1'b1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_mode  = ~mode;
        in_tri   = '0;
        @(negedge clk);
        check({tag, "_lat1"}, 256'(out_valid), 256'(1'b0));
        @(negedge clk);
        check({tag, "_valid"}, 256'(out_valid), 256'(1'b1));
        check({tag, "_tri"}, 256'(out_tri), 256'(exp_tri));
        check({tag, "_rot"}, 256'(out_rot), 256'(exp_rot));
        check({tag, "_deg"}, 256'(out_degenerate), 256'(exp_deg));
    endtask

    logic [TRI_W-1:0] s_tri  [6];
    logic             s_mode [6];
    logic [TRI_W-1:0] e_tri  [6];
    logic [1:0]       e_rot  [6];
    logic             e_deg  [6];

    int               sent;
    int               rcvd;
    int               held;
    logic             will_acc;
    logic             will_out;
    logic             prev_stall;
    logic             saw_full;
    logic [TRI_W-1:0] prev_tri;
    logic [1:0]       prev_rot;
    logic             prev_deg;

    initial begin
        tests     = 0;
        fails     = 0;
        n_rst     = 1'b0;
        in_valid  = 1'b0;
        in_mode   = 1'b0;
        in_tri    = '0;
        out_ready = 1'b1;

        #1;
        check("rst_out_valid", 256'(out_valid), 256'(1'b0));
        check("rst_out_tri", 256'(out_tri), 256'(0));
        check("rst_out_rot", 256'(out_rot), 256'(0));
        check("rst_out_deg", 256'(out_degenerate), 256'(1'b0));
        @(negedge clk);
        @(negedge clk);
        n_rst = 1'b1;
        @(negedge clk);
        check("rst_in_ready", 256'(in_ready), 256'(1'b1));

        // d = 100,109,9
        run_single("t1_long", 1'b0, mk(0,0,5, 10,0,6, 0,3,7), mk(10,0,6, 0,3,7, 0,0,5), 2'd1, 1'b0);
        run_single("t2_short", 1'b1, mk(0,0,5, 10,0,6, 0,3,7), mk(0,3,7, 0,0,5, 10,0,6), 2'd2, 1'b0);
        // d = 16,32,16
        run_single("t3_tie_long", 1'b0, mk(0,0,0, 4,0,0, 0,4,0), mk(4,0,0, 0,4,0, 0,0,0), 2'd1, 1'b0);
        run_single("t3_tie_short", 1'b1, mk(0,0,0, 4,0,0, 0,4,0), mk(0,0,0, 4,0,0, 0,4,0), 2'd0, 1'b0);
        // d1 = 8589672450, d2 = 2147352578, d3 = 2147483648
        run_single("t4_ext_long", 1'b0, mk(-32768,-32768,0, 32767,32767,0, 0,0,0),
                   mk(-32768,-32768,0, 32767,32767,0, 0,0,0), 2'd0, 1'b0);
        run_single("t4_ext_short", 1'b1, mk(-32768,-32768,0, 32767,32767,0, 0,0,0),
                   mk(32767,32767,0, 0,0,0, -32768,-32768,0), 2'd1, 1'b0);
        // d = 0,72,72
        run_single("t4_degen", 1'b0, mk(3,3,1, 3,3,1, 9,9,1), mk(3,3,1, 9,9,1, 3,3,1), 2'd1, 1'b1);

        // d = 25,26,1
        s_tri[0] = mk(0,0,1, 5,0,2, 0,1,3);       s_mode[0] = 1'b0;
        e_tri[0] = mk(5,0,2, 0,1,3, 0,0,1);       e_rot[0] = 2'd1; e_deg[0] = 1'b0;
        s_tri[1] = mk(0,0,1, 5,0,2, 0,1,3);       s_mode[1] = 1'b1;
        e_tri[1] = mk(0,1,3, 0,0,1, 5,0,2);       e_rot[1] = 2'd2; e_deg[1] = 1'b0;
        // d = 1,50,49
        s_tri[2] = mk(0,0,0, 1,0,0, 0,7,0);       s_mode[2] = 1'b1;
        e_tri[2] = mk(0,0,0, 1,0,0, 0,7,0);       e_rot[2] = 2'd0; e_deg[2] = 1'b0;
        // d = 16,65,49
        s_tri[3] = mk(-2,-2,9, 2,-2,8, -2,5,7);   s_mode[3] = 1'b0;
        e_tri[3] = mk(2,-2,8, -2,5,7, -2,-2,9);   e_rot[3] = 2'd1; e_deg[3] = 1'b0;
        // d = 0,25,25
        s_tri[4] = mk(1,1,1, 1,1,2, 4,5,3);       s_mode[4] = 1'b1;
        e_tri[4] = mk(1,1,1, 1,1,2, 4,5,3);       e_rot[4] = 2'd0; e_deg[4] = 1'b1;
        // d = 10000,1,10001
        s_tri[5] = mk(100,0,0, 0,0,0, 0,-1,0);    s_mode[5] = 1'b0;
        e_tri[5] = mk(0,-1,0, 100,0,0, 0,0,0);    e_rot[5] = 2'd2; e_deg[5] = 1'b0;

        sent       = 0;
        rcvd       = 0;
        held       = 0;
        prev_stall = 1'b0;
        saw_full   = 1'b0;
        for (int cyc = 0; cyc < 300 && rcvd < 6; cyc++) begin
            @(negedge clk);
            if (prev_stall) begin
                check("bp_stall_valid", 256'(out_valid), 256'(1'b1));
                check("bp_stall_hold", 256'({out_tri, out_rot, out_degenerate}),
                      256'({prev_tri, prev_rot, prev_deg}));
            end
            if (cyc >= 3 && cyc <= 7) out_ready = 1'b0;
            else if (cyc < 3)         out_ready = 1'b1;
            else                      out_ready = 1'($urandom_range(0, 1));
            in_valid = (sent < 6);
            if (sent < 6) begin
                in_tri  = s_tri[sent];
                in_mode = s_mode[sent];
            end
            #1;
            check("bp_in_ready", 256'(in_ready), 256'((held < 2) || out_ready));
            if (held == 2 && !in_ready) saw_full = 1'b1;
            will_acc = in_valid && in_ready;
            will_out = out_valid && out_ready;
            if (will_out) begin
                check("bp_order", 256'({out_tri, out_rot, out_degenerate}),
                      256'({e_tri[rcvd], e_rot[rcvd], e_deg[rcvd]}));
                rcvd++;
            end
            prev_stall = out_valid && !out_ready;
            prev_tri   = out_tri;
            prev_rot   = out_rot;
            prev_deg   = out_degenerate;
            @(posedge clk);
            if (will_acc) held++;
            if (will_out) held--;
            if (will_acc) sent++;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        check("bp_all_out", 256'(rcvd), 256'(6));
        check("bp_saw_full", 256'(saw_full), 256'(1'b1));

        @(negedge clk);
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_mode   = 1'b0;
        in_tri    = s_tri[0];
        @(posedge clk);
        #1;
        in_tri = s_tri[3];
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("r6_pre_valid", 256'(out_valid), 256'(1'b1));
        check("r6_pre_ready", 256'(in_ready), 256'(1'b0));
        n_rst = 1'b0;
        #1;
        check("r6_async_valid", 256'(out_valid), 256'(1'b0));
        check("r6_async_tri", 256'(out_tri), 256'(0));
        check("r6_async_ready", 256'(in_ready), 256'(1'b1));
        @(negedge clk);
        @(negedge clk);
        n_rst     = 1'b1;
        out_ready = 1'b1;
        @(negedge clk);
        check("r6_no_stale1", 256'(out_valid), 256'(1'b0));
        @(negedge clk);
        check("r6_no_stale2", 256'(out_valid), 256'(1'b0));
        run_single("r6_after", 1'b1, mk(0,0,5, 10,0,6, 0,3,7), mk(0,3,7, 0,0,5, 10,0,6), 2'd2, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
